dds_wave_gen: RTL and testbench

Direct-digital-synthesis waveform source for the signal-generator chain. It produces uint16 samples, mid-scale 0x8000, at a programmable sample rate, and feeds the delta-sigma DAC input (din), which shares the same clk/clk_en.

---
 rtl/dds_wave_gen.sv | 134 +++++++++++++
 tb/tb_dds_wave_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// Phase-accumulator waveform source (saw/triangle/square/DC) with amplitude scaling.
// A start/stop FSM drains to a phase wrap so the output always parks at mid-scale.
module dds_wave_gen #(
  parameter int PHASE_W = 24,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   div,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [1:0]         wave_sel,
  input  logic [15:0]        amp,
  output logic [15:0]        dout,
  output logic               dout_valid,
  output logic               busy
);

  // state | meaning
  // IDLE  | parked at mid-scale, phase and divider cleared
  // RUN   | one sample every div+1 enabled clocks
  // DRAIN | keep sampling until the phase wraps (or fcw is 0), then park
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                tick, restart, carry, drain_end;
  logic [PHASE_W:0]    phase_sum;
  logic [15:0]         t;
  logic signed [15:0]  w;
  logic signed [32:0]  prod;
  logic [15:0]         s;
  logic                unused_prod_bits;

  always_comb begin
    tick      = (state_q != IDLE) && (cnt_q >= div);
    restart   = (state_q == DRAIN) && start && !stop;
    phase_sum = {1'b0, phase_q} + {1'b0, fcw};
    carry     = phase_sum[PHASE_W];
    drain_end = tick && (state_q == DRAIN) && !restart && (carry || (fcw == '0));
  end

  // Offset-binary to signed is an MSB flip, so t - 32768 needs no adder.
  always_comb begin
    t = phase_q[PHASE_W-1 -: 16];
    w = '0;
    case (wave_sel)
      2'd0:    w = t ^ 16'h8000;
      2'd1:    w = t[15] ? (16'h7FFF - {t[14:0], 1'b0}) : ({t[14:0], 1'b0} ^ 16'h8000);
      2'd2:    w = t[15] ? 16'h8000 : 16'h7FFF;
      default: w = '0;
    endcase
    prod = 33'(w) * 33'($signed({1'b0, amp}));
    s    = prod[31:16];
  end

  assign unused_prod_bits = ^{prod[32], prod[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN: begin
        if (restart)        state_d = RUN;
        else if (drain_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    dout_d  = dout_q;
    valid_d = clk_en && tick;
    busy_d  = (state_d != IDLE);
    if (state_q == IDLE) begin
      cnt_d   = '0;
      phase_d = '0;
      dout_d  = 16'h8000;
    end else begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
      if (tick) begin
        if (drain_end) begin
          phase_d = '0;
          dout_d  = 16'h8000;
        end else begin
          phase_d = phase_sum[PHASE_W-1:0];
          dout_d  = s ^ 16'h8000;
        end
      end
    end
  end

  // valid_q updates on every clock so a pulse never survives a clk_en gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      cnt_q   <= '0;
      dout_q  <= 16'h8000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (clk_en) begin
        phase_q <= phase_d;
        cnt_q   <= cnt_d;
        dout_q  <= dout_d;
        busy_q  <= busy_d;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q && clk_en;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed scenarios plus randomized
// stimulus, every cycle compared against an arithmetic reference model.
module tb_dds_wave_gen;
  localparam int PW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] div = '0;
  logic [PW-1:0] fcw = '0;
  logic [1:0]    wave_sel = '0;
  logic [15:0]   amp = '0;
  logic [15:0]   dout;
  logic          dout_valid;
  logic          busy;

  dds_wave_gen #(.PHASE_W(PW), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .stop(stop),
    .div(div), .fcw(fcw), .wave_sel(wave_sel), .amp(amp),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int nmid = 0;

  // Reference model: mode 0 idle, 1 run, 2 drain.
  int     m_mode;
  longint m_phase, m_cnt;
  int     m_dout;
  bit     m_vq;

  function automatic int shape_sample(int t, int sel, int a);
    longint w, p, s;
    case (sel)
      0:       w = t - 32768;
      1:       w = (t < 32768) ? 2 * t - 32768 : 32767 - 2 * (t - 32768);
      2:       w = (t >= 32768) ? -32768 : 32767;
      default: w = 0;
    endcase
    p = w * a;
    if (p >= 0) s = p / 65536;
    else        s = -((-p + 65535) / 65536);
    return int'(s + 32768);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cnt = 0; m_dout = 32768; m_vq = 0;
  endtask

  task automatic model_step();
    bit     tk, wrap;
    int     nmode;
    longint sum;
    if (!rst_n) begin model_reset(); return; end
    m_vq = 0;
    if (!clk_en) return;
    if (m_mode == 0) begin
      m_phase = 0; m_cnt = 0; m_dout = 32768;
      if (start) m_mode = 1;
      return;
    end
    tk = (m_cnt >= longint'(div));
    m_cnt = tk ? 0 : m_cnt + 1;
    nmode = m_mode;
    if (m_mode == 1 && stop) nmode = 2;
    if (m_mode == 2 && start && !stop) nmode = 1;
    if (tk) begin
      m_vq = 1;
      sum  = m_phase + longint'(fcw);
      wrap = (sum >= (longint'(1) << PW));
      if (m_mode == 2 && nmode == 2 && (wrap || fcw == 0)) begin
        m_dout = 32768; m_phase = 0; nmode = 0;
      end else begin
        m_dout  = shape_sample(int'(m_phase >> (PW - 16)), int'(wave_sel), int'(amp));
        m_phase = sum % (longint'(1) << PW);
      end
    end
    m_mode = nmode;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_vq && clk_en);
    chk("busy", busy, m_mode != 0);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int k = 0;
    do begin cycle(); k++; end while (!dout_valid && k < max_cyc);
    chk(tag, dout_valid, 1);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k = 0;
    do begin cycle(); k++; end while (busy && k < max_cyc);
    chk(tag, busy, 0);
  endtask

  task automatic run_mid(input int n);
    repeat (n) begin
      cycle();
      if (dout_valid && dout == 16'h8000) nmid++;
    end
  endtask

  initial begin
    int          gap, nv, nsamp, k, nsq_hi, nsq_lo;
    int          p1, p2, p3;
    logic [15:0] saw_s [0:31];
    logic [15:0] sq_s  [0:19];

    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (4) cycle();
    chk("idle_after_reset", busy, 0);

    // Saw, full scale, one sample per clock
    div = 0; fcw = 24'h100000; amp = 16'hFFFF; wave_sel = 0;
    start = 1; cycle(); start = 0;
    nv = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      saw_s[i] = dout;
      nv += int'(dout_valid);
    end
    chk("saw_first", saw_s[0], 16'h0000);
    chk("saw_second", saw_s[1], 16'h1000);
    chk("saw_valid_every_clk", nv, 32);

    // Square at half amplitude; phase is back at 0 after 32 ticks
    wave_sel = 2; amp = 16'h8000;
    nsq_hi = 0; nsq_lo = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      sq_s[i] = dout;
      if (i < 8 && dout == 16'hBFFF) nsq_hi++;
      if (i >= 8 && i < 16 && dout == 16'h4000) nsq_lo++;
    end
    chk("square_high_run", nsq_hi, 8);
    chk("square_low_run", nsq_lo, 8);
    chk("square_repeat", sq_s[16], 16'hBFFF);

    // Rate and clock enable
    div = 4;
    wait_valid("rate_sync", 20);
    gap = 0;
    do begin cycle(); gap++; end while (!dout_valid && gap < 20);
    chk("rate_spacing", gap, 5);
    gap = 0;
    repeat (2) begin cycle(); gap++; end
    clk_en = 0; nv = 0;
    repeat (3) begin cycle(); gap++; nv += int'(dout_valid); end
    chk("no_pulse_clk_en_low", nv, 0);
    clk_en = 1;
    do begin cycle(); gap++; end while (!dout_valid && gap < 20);
    chk("rate_spacing_stretched", gap, 8);
    stop = 1; wait_idle("stop_to_idle", 200); stop = 0;

    // Triangle drain: stop after 5th sample, park on the wrap tick
    wave_sel = 1; amp = 16'hFFFF; fcw = 24'h100000; div = 0;
    start = 1; cycle(); start = 0;
    nsamp = 0; k = 0;
    do begin
      cycle(); k++;
      if (dout_valid) nsamp++;
      if (nsamp == 5) stop = 1;
    end while (busy && k < 60);
    chk("drain_samples", nsamp, 16);
    chk("drain_park_dout", dout, 16'h8000);
    chk("drain_park_valid", dout_valid, 1);
    stop = 0;

    // Restart from DRAIN keeps phase, no mid-scale sample
    wave_sel = 0;
    start = 1; cycle(); start = 0;
    nmid = 0;
    run_mid(2);
    stop = 1; run_mid(2);
    stop = 0; start = 1; run_mid(1);
    start = 0; run_mid(2);
    chk("restart_no_midscale", nmid, 0);
    chk("restart_busy", busy, 1);

    // start and stop together in RUN: stop wins
    start = 1; stop = 1;
    wait_idle("both_high_drains", 40);
    start = 0; stop = 0;

    // fcw = 0 in DRAIN parks on the next tick
    wave_sel = 0; fcw = 24'h100000; div = 2;
    start = 1; cycle(); start = 0;
    wait_valid("fcw0_sync", 10);
    fcw = 0; stop = 1; k = 0;
    do begin cycle(); k++; end while (busy && k < 10);
    chk("fcw0_park_cycles", k, 3);
    chk("fcw0_park_dout", dout, 16'h8000);
    stop = 0;

    // fcw change between ticks shows up one sample later
    fcw = 24'h010000; div = 3; wave_sel = 0; amp = 16'hFFFF;
    start = 1; cycle(); start = 0;
    wait_valid("fc_p0", 10);
    wait_valid("fc_p1", 10); p1 = int'(dout);
    fcw = 24'h040000;
    wait_valid("fc_p2", 10); p2 = int'(dout);
    wait_valid("fc_p3", 10); p3 = int'(dout);
    chk("fcw_p2", p2, 16'h0200);
    chk("fcw_old_step", p2 - p1, 16'h0100);
    chk("fcw_new_step", p3 - p2, 16'h0400);
    stop = 1; wait_idle("fc_idle", 400); stop = 0;

    // Randomized
    repeat (500) begin
      if ($urandom_range(0, 15) == 0) begin
        fcw      = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(24'h020000, 24'hFFFFFF));
        amp      = 16'($urandom);
        wave_sel = 2'($urandom_range(0, 3));
        div      = DW'($urandom_range(0, 3));
      end
      clk_en = ($urandom_range(0, 4) != 0);
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 9) == 0);
      cycle();
    end
    clk_en = 1; start = 0; stop = 1;
    wait_idle("rand_idle", 800);
    stop = 0;

    // Asynchronous reset mid-RUN
    wave_sel = 0; amp = 16'hFFFF; fcw = 24'h100000; div = 0;
    start = 1; cycle(); start = 0;
    repeat (2) cycle();
    #2 rst_n = 0;
    #1;
    chk("async_rst_dout", dout, 16'h8000);
    chk("async_rst_valid", dout_valid, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (4) cycle();
    chk("stay_idle_after_release", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
